hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard and forwarding controller for the in-order pipeline, sitting beside decode and driving fetch/decode hold and the EX operand muxes. It tracks the destination register of every instruction in flight across NUM_STAGES post-decode stages. From that state it generates load-use stalls, branch-flush bubbles, per-operand forwarding selects, and an end-of-program drain handshake (RUN/DRAIN/DONE).

## Interface
- ADDR_LINE_REG, 5, register-address width
- NUM_STAGES, 3, tracked stages after decode (0 = EX, 1 = MEM, 2 = WB, ...); legal range 2..8
- SEL_W, $clog2(NUM_STAGES+1), forwarding-select width (derived, not overridable)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- issue_valid  in  1  decode presents an instruction this cycle
- issue_rs  in  ADDR_LINE_REG  source register A
- issue_rt  in  ADDR_LINE_REG  source register B
- issue_uses_rt  in  1  instruction reads rt (0 for I-type/jumps)
- issue_dest  in  ADDR_LINE_REG  destination register
- issue_wen  in  1  instruction writes issue_dest
- issue_is_load  in  1  result available only after MEM
- flush  in  1  branch taken in EX; kill the instruction in decode
- drain  in  1  program finished; single-cycle pulse, stop issuing
- accept  out  1  issue entered stage 0 this cycle
- stall  out  1  hold PC and IF/ID register
- fwd_rs_sel  out  SEL_W  0 = register file, k = result of stage k-1
- fwd_rt_sel  out  SEL_W  as above for rt
- occupancy  out  $clog2(NUM_STAGES+1)  valid entries in flight
- drained  out  1  sticky; pipeline empty after drain

## Operation
- Entry per stage: {valid, dest, wen, is_load}.
- Every cycle the entries shift: stage[i+1] <= stage[i]. Stage NUM_STAGES-1 retires.
- stage[0] <= issued entry when accept is 1; otherwise a bubble (valid=0).
- Match on stage k: valid & wen & dest != 0 & dest == source. rt is ignored when issue_uses_rt=0.
- Youngest match (lowest k) wins. fwd_*_sel = k+1, or 0 if there is no match.
- Load-use hazard: the youngest match for rs or rt is stage 0 with is_load=1.
- stall = issue_valid & load_use & state==RUN & !flush.
- accept = issue_valid & state==RUN & !flush & !stall.
- Flush has priority over stall: the bubble is inserted, stall=0, and the decoded instruction is dropped.
- During stall, fwd selects still reflect the current match. Decode ignores them.
- Register 0 never creates a hazard or a forward.
- State machine:
  - RUN -> DRAIN on drain=1. Issue is blocked from that same cycle.
  - DRAIN -> DONE when all stage valid bits are 0. DRAIN is entered even if the pipeline is already empty.
  - DONE holds until reset. In DONE, drained=1.
  - drain in DRAIN/DONE is ignored.
- occupancy = popcount of valid bits, registered alongside the stage entries.

## Timing
- Reset values:
  - All entries invalid, state RUN.
  - occupancy=0, drained=0.
  - stall=0, accept=0 until issue_valid; fwd selects=0.
- stall, accept and fwd_*_sel are combinational from the issue inputs plus registered stage state, all in the same cycle. There is no combinational path from flush to fwd selects.
- Load-use stall lasts exactly 1 cycle: the load moves to stage 1, and the retry forwards with sel=2.
- Entry latency: accepted at edge n, visible in stage 0 after edge n, retires after edge n+NUM_STAGES.
- drained rises one cycle after the edge at which the last valid entry retires.
- The asynchronous reset assertion mid-DRAIN or mid-stall clears to RUN/empty immediately. Deassertion is synchronised externally.
- Simultaneous drain and issue_valid: the issue is rejected (accept=0).

## Test plan
- Back-to-back ALU dependency: add r3 is accepted, then sub r4,r3,r1 -> fwd_rs_sel=1, stall=0, accept=1. On the next issue using r3 -> sel=2, then sel=3, then sel=0.
- Load-use: lw r5 is followed by add r6,r5,r5 -> stall=1 for exactly 1 cycle with accept=0. On retry, fwd_rs_sel=fwd_rt_sel=2 and stall=0.
- Youngest-wins and r0: r7 is in stages 0 and 2 -> sel=1. An instruction writing r0 in stage 0 with a reader of r0 -> sel=0, no stall.
- Flush during load-use: flush=1 with a load-use hazard present -> stall=0, accept=0, bubble in stage 0, occupancy drops by 1 on the next cycle.
- Drain: 3 entries in flight, drain pulse -> accept stays 0, occupancy steps 3,2,1,0, and drained=1 one cycle after it reaches 0. Assert reset low -> drained=0 and state RUN.
- Parameter sweep with NUM_STAGES=2 and NUM_STAGES=5: a dependency at the deepest stage gives sel=NUM_STAGES, and the following cycle gives sel=0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode <-> hazard scoreboard bundle: issue request in, hold/forward/drain status out.
// master = decode side, slave = scoreboard side.
interface hazard_scoreboard_if #(
  parameter int unsigned ADDR_LINE_REG = 5,
  parameter int unsigned NUM_STAGES    = 3
);
  localparam int unsigned SEL_W = $clog2(NUM_STAGES + 1);

  logic                     issue_valid;
  logic [ADDR_LINE_REG-1:0] issue_rs;
  logic [ADDR_LINE_REG-1:0] issue_rt;
  logic                     issue_uses_rt;
  logic [ADDR_LINE_REG-1:0] issue_dest;
  logic                     issue_wen;
  logic                     issue_is_load;
  logic                     flush;
  logic                     drain;

  logic                     accept;
  logic                     stall;
  logic [SEL_W-1:0]         fwd_rs_sel;
  logic [SEL_W-1:0]         fwd_rt_sel;
  logic [SEL_W-1:0]         occupancy;
  logic                     drained;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_uses_rt, issue_dest, issue_wen, issue_is_load,
    output flush, drain,
    input  accept, stall, fwd_rs_sel, fwd_rt_sel, occupancy, drained
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_uses_rt, issue_dest, issue_wen, issue_is_load,
    input  flush, drain,
    output accept, stall, fwd_rs_sel, fwd_rt_sel, occupancy, drained
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destination registers after decode and derives load-use stalls,
// operand forwarding selects and the RUN/DRAIN/DONE end-of-program handshake.
module hazard_scoreboard #(
  parameter int unsigned ADDR_LINE_REG = 5,
  parameter int unsigned NUM_STAGES    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_scoreboard_if.slave   bus
);
  localparam int unsigned SEL_W = $clog2(NUM_STAGES + 1);

  typedef struct packed {
    logic                     valid;
    logic [ADDR_LINE_REG-1:0] dest;
    logic                     wen;
    logic                     is_load;
  } entry_t;

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e                  state_q, state_d;
  entry_t [NUM_STAGES-1:0] stage_q, stage_d;
  logic   [SEL_W-1:0]      occ_q, occ_d;

  logic [NUM_STAGES-1:0] hit_rs, hit_rt;
  logic [SEL_W-1:0]      rs_sel, rt_sel;
  logic                  load_use, issue_ok, stall, accept, any_valid;

  // Register 0 is hardwired, so it never matches.
  always_comb begin
    hit_rs = '0;
    hit_rt = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      hit_rs[k] = stage_q[k].valid & stage_q[k].wen & (stage_q[k].dest != '0) &
                  (stage_q[k].dest == bus.issue_rs);
      hit_rt[k] = stage_q[k].valid & stage_q[k].wen & (stage_q[k].dest != '0) &
                  (stage_q[k].dest == bus.issue_rt) & bus.issue_uses_rt;
    end
  end

  // Walk oldest to youngest so the youngest match is the last one written.
  always_comb begin
    rs_sel = '0;
    rt_sel = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (hit_rs[k]) rs_sel = SEL_W'(k + 1);
      if (hit_rt[k]) rt_sel = SEL_W'(k + 1);
    end
  end

  // A stage-0 match is always the youngest, so only stage 0 can cause load-use.
  assign load_use = stage_q[0].is_load & (hit_rs[0] | hit_rt[0]);
  assign issue_ok = (state_q == StRun) & ~bus.drain;
  assign stall    = bus.issue_valid & load_use & issue_ok & ~bus.flush;
  assign accept   = bus.issue_valid & issue_ok & ~bus.flush & ~stall;

  always_comb begin
    stage_d = '0;
    if (accept) begin
      stage_d[0].valid   = 1'b1;
      stage_d[0].dest    = bus.issue_dest;
      stage_d[0].wen     = bus.issue_wen;
      stage_d[0].is_load = bus.issue_is_load;
    end
    for (int i = 1; i < NUM_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    occ_d = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      occ_d = occ_d + SEL_W'(stage_d[i].valid);
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      any_valid = any_valid | stage_q[i].valid;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:   if (bus.drain) state_d = StDrain;
      StDrain: if (!any_valid) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      stage_q <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      occ_q   <= occ_d;
    end
  end

  assign bus.accept     = accept;
  assign bus.stall      = stall;
  assign bus.fwd_rs_sel = rs_sel;
  assign bus.fwd_rt_sel = rt_sel;
  assign bus.occupancy  = occ_q;
  assign bus.drained    = (state_q == StDone);
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed checks of the hazard scoreboard at depths 3 (main), 2 and 5.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.ADDR_LINE_REG(5), .NUM_STAGES(3)) bus_a ();
  hazard_scoreboard_if #(.ADDR_LINE_REG(5), .NUM_STAGES(2)) bus_b ();
  hazard_scoreboard_if #(.ADDR_LINE_REG(5), .NUM_STAGES(5)) bus_c ();

  hazard_scoreboard #(.ADDR_LINE_REG(5), .NUM_STAGES(3)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  hazard_scoreboard #(.ADDR_LINE_REG(5), .NUM_STAGES(2)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));
  hazard_scoreboard #(.ADDR_LINE_REG(5), .NUM_STAGES(5)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_a(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic [4:0] dest, input logic wen, input logic ld);
    bus_a.issue_valid   = 1'b1;
    bus_a.issue_rs      = rs;
    bus_a.issue_rt      = rt;
    bus_a.issue_uses_rt = uses_rt;
    bus_a.issue_dest    = dest;
    bus_a.issue_wen     = wen;
    bus_a.issue_is_load = ld;
    bus_a.flush         = 1'b0;
    bus_a.drain         = 1'b0;
  endtask

  task automatic idle_a();
    bus_a.issue_valid = 1'b0;
    bus_a.flush       = 1'b0;
    bus_a.drain       = 1'b0;
  endtask

  task automatic idle_all();
    issue_a(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle_a();
    bus_b.issue_valid = 1'b0; bus_b.issue_rs = '0; bus_b.issue_rt = '0;
    bus_b.issue_uses_rt = 1'b0; bus_b.issue_dest = '0; bus_b.issue_wen = 1'b0;
    bus_b.issue_is_load = 1'b0; bus_b.flush = 1'b0; bus_b.drain = 1'b0;
    bus_c.issue_valid = 1'b0; bus_c.issue_rs = '0; bus_c.issue_rt = '0;
    bus_c.issue_uses_rt = 1'b0; bus_c.issue_dest = '0; bus_c.issue_wen = 1'b0;
    bus_c.issue_is_load = 1'b0; bus_c.flush = 1'b0; bus_c.drain = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle_all();
    #2;
    check("rst_occ", int'(bus_a.occupancy), 0);
    check("rst_drained", int'(bus_a.drained), 0);
    check("rst_stall", int'(bus_a.stall), 0);
    check("rst_accept", int'(bus_a.accept), 0);
    check("rst_fwd_rs", int'(bus_a.fwd_rs_sel), 0);
    check("rst_fwd_rt", int'(bus_a.fwd_rt_sel), 0);
    step();
    reset = 1'b1;

    // Back-to-back ALU dependency on r3
    issue_a(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); #1;
    check("alu_add_accept", int'(bus_a.accept), 1);
    check("alu_add_fwd", int'(bus_a.fwd_rs_sel), 0);
    step();
    issue_a(5'd3, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0); #1;
    check("alu_sub_fwd", int'(bus_a.fwd_rs_sel), 1);
    check("alu_sub_stall", int'(bus_a.stall), 0);
    check("alu_sub_accept", int'(bus_a.accept), 1);
    step();
    issue_a(5'd3, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0); #1;
    check("alu_sel2", int'(bus_a.fwd_rs_sel), 2);
    step();
    issue_a(5'd3, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0); #1;
    check("alu_sel3_rs", int'(bus_a.fwd_rs_sel), 3);
    check("alu_sel3_rt", int'(bus_a.fwd_rt_sel), 3);
    step();
    issue_a(5'd3, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    check("alu_sel0", int'(bus_a.fwd_rs_sel), 0);
    check("alu_occ3", int'(bus_a.occupancy), 3);
    step();
    idle_a();
    repeat (3) step();
    check("alu_empty", int'(bus_a.occupancy), 0);

    // Load-use: lw r5 then add r6,r5,r5
    issue_a(5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b1); #1;
    check("lu_lw_accept", int'(bus_a.accept), 1);
    step();
    issue_a(5'd5, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0); #1;
    check("lu_stall", int'(bus_a.stall), 1);
    check("lu_stall_accept", int'(bus_a.accept), 0);
    check("lu_stall_fwd", int'(bus_a.fwd_rs_sel), 1);
    step();
    check("lu_retry_stall", int'(bus_a.stall), 0);
    check("lu_retry_accept", int'(bus_a.accept), 1);
    check("lu_retry_rs", int'(bus_a.fwd_rs_sel), 2);
    check("lu_retry_rt", int'(bus_a.fwd_rt_sel), 2);
    step();
    issue_a(5'd1, 5'd6, 1'b0, 5'd10, 1'b1, 1'b0); #1;
    check("rt_unused", int'(bus_a.fwd_rt_sel), 0);
    bus_a.issue_uses_rt = 1'b1; #1;
    check("rt_used", int'(bus_a.fwd_rt_sel), 1);
    step();
    idle_a();
    repeat (3) step();

    // Youngest wins and r0 never forwards or stalls
    issue_a(5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0); step();
    issue_a(5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0); step();
    issue_a(5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0); step();
    issue_a(5'd7, 5'd2, 1'b1, 5'd0, 1'b1, 1'b1); #1;
    check("young_rs", int'(bus_a.fwd_rs_sel), 1);
    check("young_rt", int'(bus_a.fwd_rt_sel), 2);
    step();
    issue_a(5'd0, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0); #1;
    check("r0_rs", int'(bus_a.fwd_rs_sel), 0);
    check("r0_rt", int'(bus_a.fwd_rt_sel), 0);
    check("r0_stall", int'(bus_a.stall), 0);
    check("r0_accept", int'(bus_a.accept), 1);
    step();
    idle_a();
    repeat (3) step();

    // Flush with a load-use hazard present
    issue_a(5'd1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0); step();
    issue_a(5'd1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0); step();
    issue_a(5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1); step();
    issue_a(5'd5, 5'd0, 1'b0, 5'd17, 1'b1, 1'b0);
    bus_a.flush = 1'b1; #1;
    check("fl_stall", int'(bus_a.stall), 0);
    check("fl_accept", int'(bus_a.accept), 0);
    check("fl_occ_before", int'(bus_a.occupancy), 3);
    step();
    check("fl_occ_after", int'(bus_a.occupancy), 2);
    bus_a.flush = 1'b0; #1;
    check("fl_after_fwd", int'(bus_a.fwd_rs_sel), 2);
    check("fl_after_stall", int'(bus_a.stall), 0);
    step();
    idle_a();
    repeat (3) step();

    // Drain with three entries in flight
    issue_a(5'd1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0); step();
    issue_a(5'd1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0); step();
    issue_a(5'd1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0); step();
    bus_a.drain = 1'b1; #1;
    check("dr_accept_pulse", int'(bus_a.accept), 0);
    check("dr_occ3", int'(bus_a.occupancy), 3);
    step();
    bus_a.drain = 1'b0;
    check("dr_occ2", int'(bus_a.occupancy), 2);
    check("dr_accept_drain", int'(bus_a.accept), 0);
    step();
    check("dr_occ1", int'(bus_a.occupancy), 1);
    step();
    check("dr_occ0", int'(bus_a.occupancy), 0);
    check("dr_not_yet", int'(bus_a.drained), 0);
    step();
    check("dr_drained", int'(bus_a.drained), 1);
    check("dr_done_accept", int'(bus_a.accept), 0);
    bus_a.drain = 1'b1;
    step();
    bus_a.drain = 1'b0;
    check("dr_sticky", int'(bus_a.drained), 1);
    reset = 1'b0; #1;
    check("dr_rst_drained", int'(bus_a.drained), 0);
    reset = 1'b1; #1;
    check("dr_rst_accept", int'(bus_a.accept), 1);
    step();
    check("dr_rst_occ", int'(bus_a.occupancy), 1);
    idle_a();
    repeat (3) step();

    // Depth sweep: producer of r20, then readers each cycle
    bus_b.issue_valid = 1'b1; bus_b.issue_rs = 5'd1; bus_b.issue_dest = 5'd20;
    bus_b.issue_wen = 1'b1;
    bus_c.issue_valid = 1'b1; bus_c.issue_rs = 5'd1; bus_c.issue_dest = 5'd20;
    bus_c.issue_wen = 1'b1;
    step();
    bus_b.issue_rs = 5'd20; bus_b.issue_dest = 5'd0; bus_b.issue_wen = 1'b0;
    bus_c.issue_rs = 5'd20; bus_c.issue_dest = 5'd0; bus_c.issue_wen = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      check($sformatf("ns2_sel_k%0d", k), int'(bus_b.fwd_rs_sel), (k <= 2) ? k : 0);
      check($sformatf("ns5_sel_k%0d", k), int'(bus_c.fwd_rs_sel), (k <= 5) ? k : 0);
      step();
    end
    idle_all();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
